// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 tables, state/FSM types and round/key-schedule helper functions
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef enum logic [2:0] {IDLE, KEXP, ARK, ROUND, DONE} fsm_t;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [0:87] RCON = 88'h00_01_02_04_08_10_20_40_80_1b_36;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        return RCON[{i, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        return inv ? INV_SBOX[{b, 3'b000} +: 8] : SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_state_t sub_bytes(input aes_state_t s, input logic inv);
        aes_state_t o;
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = sub_byte(s[127 - 8 * i -: 8], inv);
        return o;
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                o[127 - 8 * (4 * c + w) -: 8] = s[127 - 8 * (4 * ((c + w) % 4) + w) -: 8];
        return o;
    endfunction

    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                o[127 - 8 * (4 * c + w) -: 8] = s[127 - 8 * (4 * ((c - w + 4) % 4) + w) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3, xtime(a1 ^ a2) ^ a2 ^ a3 ^ a0,
                xtime(a2 ^ a3) ^ a3 ^ a0 ^ a1, xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2};
    endfunction

    // InvMixColumns factored as a cheap {05,00,04,00} pre-multiply followed by MixColumns
    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] u, v;
        u = xtime(xtime(w[31:24] ^ w[15:8]));
        v = xtime(xtime(w[23:16] ^ w[7:0]));
        return mix_col(w ^ {u, v, u, v});
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) o[127 - 32 * c -: 32] = mix_col(s[127 - 32 * c -: 32]);
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) o[127 - 32 * c -: 32] = inv_mix_col(s[127 - 32 * c -: 32]);
        return o;
    endfunction

    function automatic aes_state_t key_step(input aes_state_t k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        t = {sub_byte(w3[23:16], 1'b0) ^ rc, sub_byte(w3[15:8], 1'b0),
             sub_byte(w3[7:0], 1'b0), sub_byte(w3[31:24], 1'b0)};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES round, forward or inverse, with optional MixColumns skip
module aes_round import aes_pkg::*; #(
    parameter int ENABLE_DEC = 1
) (
    input  aes_state_t state,
    input  aes_state_t rk,
    input  logic       mode,
    input  logic       final_round,
    output aes_state_t next_state
);

    aes_state_t enc_t, dec_t;
    logic       dec;

    assign dec        = mode && ENABLE_DEC != 0;
    assign enc_t      = shift_rows(sub_bytes(state, 1'b0));
    assign dec_t      = sub_bytes(inv_shift_rows(state), 1'b1) ^ rk;
    assign next_state = dec ? (final_round ? dec_t : inv_mix_columns(dec_t))
                            : (final_round ? enc_t : mix_columns(enc_t)) ^ rk;

endmodule

// File: rtl/aes_cipher_core.sv
// aes_cipher_core: iterative AES-128 encrypt/decrypt engine with cached key schedule
module aes_cipher_core import aes_pkg::*; #(
    parameter int ROUND_UNROLL = 1,
    parameter int ENABLE_DEC   = 1,
    parameter int KEY_CACHE    = 1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         AES_START,
    input  logic         AES_MODE,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_IN,
    output logic [127:0] AES_MSG_OUT,
    output logic         AES_BUSY,
    output logic         AES_DONE
);

    if (ROUND_UNROLL != 1 && ROUND_UNROLL != 2 && ROUND_UNROLL != 5 && ROUND_UNROLL != 10) begin : g_bad_unroll
        $fatal(1, "ROUND_UNROLL must be 1, 2, 5 or 10");
    end

    fsm_t       st;
    aes_state_t state_q, cached_key;
    aes_state_t rk [11];
    aes_state_t chain [ROUND_UNROLL + 1];
    logic [3:0] r;
    logic       mode_q, key_valid;

    assign chain[0] = state_q;

    for (genvar i = 0; i < ROUND_UNROLL; i++) begin : g_rnd
        logic [3:0] n, k;
        assign n = r + 4'(i);
        assign k = (n > 4'd10) ? 4'd10 : (mode_q ? 4'd10 - n : n);
        aes_round #(.ENABLE_DEC(ENABLE_DEC)) u_round (
            .state       (chain[i]),
            .rk          (rk[k]),
            .mode        (mode_q),
            .final_round (n == 4'd10),
            .next_state  (chain[i + 1])
        );
    end

    // Control FSM, key expansion into the round-key file and the round datapath register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            st          <= IDLE;
            state_q     <= '0;
            cached_key  <= '0;
            r           <= '0;
            mode_q      <= 1'b0;
            key_valid   <= 1'b0;
            AES_MSG_OUT <= '0;
            AES_BUSY    <= 1'b0;
            AES_DONE    <= 1'b0;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
        end else begin
            AES_DONE <= 1'b0;
            case (st)
                IDLE: if (AES_START) begin
                    state_q  <= AES_MSG_IN;
                    mode_q   <= AES_MODE && ENABLE_DEC != 0;
                    AES_BUSY <= 1'b1;
                    if (KEY_CACHE != 0 && key_valid && AES_KEY == cached_key) st <= ARK;
                    else begin
                        rk[0]     <= AES_KEY;
                        r         <= 4'd1;
                        key_valid <= 1'b0;
                        st        <= KEXP;
                    end
                end
                KEXP: begin
                    rk[r] <= key_step(rk[r - 4'd1], rcon(r));
                    r     <= r + 4'd1;
                    if (r == 4'd10) begin
                        cached_key <= rk[0];
                        key_valid  <= 1'b1;
                        st         <= ARK;
                    end
                end
                ARK: begin
                    state_q <= state_q ^ (mode_q ? rk[10] : rk[0]);
                    r       <= 4'd1;
                    st      <= ROUND;
                end
                ROUND: begin
                    state_q <= chain[ROUND_UNROLL];
                    r       <= r + 4'(ROUND_UNROLL);
                    if (r == 4'(11 - ROUND_UNROLL)) begin
                        AES_MSG_OUT <= chain[ROUND_UNROLL];
                        AES_DONE    <= 1'b1;
                        st          <= DONE;
                    end
                end
                DONE: begin
                    AES_BUSY <= 1'b0;
                    st       <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_core.sv
// tb_aes_cipher_core: directed FIPS-197 vectors, latency and handshake checks over several configurations
module tb_aes_cipher_core;

    localparam int NDUT = 6;
    localparam int UN [NDUT]   = '{1, 2, 5, 10, 1, 1};
    localparam int KC [NDUT]   = '{1, 1, 1, 1, 0, 1};
    localparam int ED [NDUT]   = '{1, 1, 1, 1, 1, 0};
    localparam int MISS [NDUT] = '{22, 17, 14, 13, 22, 22};
    localparam int HIT [NDUT]  = '{12, 7, 4, 3, 12, 12};

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] M1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] M2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic [NDUT-1:0]   start;
    logic              mode;
    logic [127:0]      key, msg;
    logic [127:0]      out_v [NDUT];
    logic [NDUT-1:0]   busy_v, done_v;
    int                n_chk = 0;
    int                n_fail = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        aes_cipher_core #(.ROUND_UNROLL(UN[g]), .ENABLE_DEC(ED[g]), .KEY_CACHE(KC[g])) u_dut (
            .CLK         (CLK),
            .RESET       (RESET),
            .AES_START   (start[g]),
            .AES_MODE    (mode),
            .AES_KEY     (key),
            .AES_MSG_IN  (msg),
            .AES_MSG_OUT (out_v[g]),
            .AES_BUSY    (busy_v[g]),
            .AES_DONE    (done_v[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One launch on DUT d; inputs are scrambled right after the start edge
    task automatic op(input int d, input logic m, input logic [127:0] k, input logic [127:0] x,
                      output logic [127:0] res, output int lat);
        key = k;
        msg = x;
        mode = m;
        start[d] = 1'b1;
        @(posedge CLK);
        #1;
        start[d] = 1'b0;
        key = ~k;
        msg = ~x;
        mode = ~m;
        res = '0;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge CLK);
            if (c == 1) chk($sformatf("u%0d_busy_c1", d), busy_v[d], 1);
            if (done_v[d]) begin
                lat = c;
                res = out_v[d];
            end
        end
        @(negedge CLK);
        chk($sformatf("u%0d_after_done", d), {done_v[d], busy_v[d]}, 0);
    endtask

    initial begin
        logic [127:0] res, res2;
        int lat, lat2, nd;
        logic b13;
        start = '0;
        mode = 1'b0;
        key = '0;
        msg = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_out", out_v[0], 0);
        chk("rst_busy", busy_v[0], 0);
        chk("rst_done", done_v[0], 0);
        for (int d = 0; d < 4; d++) begin
            op(d, 1'b0, K1, M1, res, lat);
            chk($sformatf("u%0d_enc_k1", d), res, C1);
            chk($sformatf("u%0d_enc_k1_lat", d), lat, MISS[d]);
            op(d, 1'b1, K1, C1, res, lat);
            chk($sformatf("u%0d_dec_k1", d), res, M1);
            chk($sformatf("u%0d_dec_k1_lat", d), lat, HIT[d]);
        end
        op(0, 1'b0, K2, M2, res, lat);
        chk("enc_k2", res, C2);
        chk("enc_k2_lat", lat, 22);
        op(0, 1'b1, K2, C2, res, lat);
        chk("dec_k2", res, M2);
        chk("dec_k2_lat", lat, 12);
        key = K1;
        msg = M1;
        mode = 1'b0;
        start[0] = 1'b1;
        @(posedge CLK);
        #1;
        start[0] = 1'b0;
        nd = 0;
        lat = 0;
        res = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (done_v[0]) begin
                nd++;
                if (lat == 0) begin
                    lat = c;
                    res = out_v[0];
                end
            end
            start[0] = (c == 3 || c == 15);
            msg = M2;
        end
        chk("busy_start_ndone", nd, 1);
        chk("busy_start_lat", lat, 22);
        chk("busy_start_res", res, C1);
        key = K1;
        msg = M1;
        mode = 1'b0;
        start[0] = 1'b1;
        @(posedge CLK);
        #1;
        lat = 0;
        lat2 = 0;
        res = '0;
        res2 = '0;
        b13 = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (done_v[0]) begin
                if (lat == 0) begin
                    lat = c;
                    res = out_v[0];
                end else if (lat2 == 0) begin
                    lat2 = c;
                    res2 = out_v[0];
                end
            end
            if (c == 13) b13 = busy_v[0];
            if (c == 14) start[0] = 1'b0;
        end
        chk("held_first_lat", lat, 12);
        chk("held_first_res", res, C1);
        chk("held_idle_busy", b13, 0);
        chk("held_second_lat", lat2, 25);
        chk("held_second_res", res2, C1);
        key = K1;
        msg = M1;
        mode = 1'b0;
        start[0] = 1'b1;
        @(posedge CLK);
        #1;
        start[0] = 1'b0;
        repeat (6) @(negedge CLK);
        chk("pre_rst_busy", busy_v[0], 1);
        chk("pre_rst_out", out_v[0], C1);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rst_out", out_v[0], 0);
        chk("async_rst_busy", busy_v[0], 0);
        chk("async_rst_done", done_v[0], 0);
        @(negedge CLK);
        RESET = 1'b0;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (done_v[0]) nd++;
        end
        chk("rst_no_done", nd, 0);
        op(0, 1'b0, K1, M1, res, lat);
        chk("post_rst_res", res, C1);
        chk("post_rst_lat", lat, 22);
        for (int i = 0; i < 2; i++) begin
            op(4, 1'b0, K1, M1, res, lat);
            chk($sformatf("nocache_res%0d", i), res, C1);
            chk($sformatf("nocache_lat%0d", i), lat, 22);
        end
        op(5, 1'b1, K1, M1, res, lat);
        chk("nodec_res", res, C1);
        chk("nodec_lat", lat, 22);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
